// File: rtl/persiana_ctrl_multi.sv
// -----------------------------------------------------------------------------------------------
// persiana_ctrl_multi
//
// Motorised-blind controller. Drives subir/bajar toward a target stop chosen either by a manual
// command or, in auto mode, by a two-bit light level sampled on every prescaler tick. The blind
// reports its position through one sensor per stop (index 0 = closed, NUM_POS-1 = open).
// A motion watchdog, an end-stop guard and a multi-sensor check latch the controller into FAULT.
// FAULT is left only by reset or by a new command.
//
// Optional feature: define PERSIANA_DEADTIME_EN to insert a DEAD state of DEAD_TK ticks on every
// direction reversal. Without it, a reversal costs a single IDLE clock with the motor off.
//
// Ports
//   clk        in   1        system clock
//   reseteo    in   1        asynchronous reset, active high
//   cmd_valid  in   1        one-clock command strobe
//   cmd_pos    in   POS_W    manual target, values >= NUM_POS clamp to NUM_POS-1
//   cmd_auto   in   1        with cmd_valid: 1 enters auto mode, 0 leaves it and loads cmd_pos
//   sensor     in   2        light level 00 closed, 01 middle, 10 open, 11 hold
//   pos_sens   in   NUM_POS  stop sensors, bit i = blind at stop i
//   subir      out  1        motor up (registered)
//   bajar      out  1        motor down (registered)
//   tick       out  1        one-clock pulse every PRESC_DIV clocks
//   busy       out  1        motor running or in reversal dead time (registered)
//   fault      out  1        controller in FAULT (registered)
//   cur_pos    out  POS_W    last stop seen by exactly one sensor (registered)
// -----------------------------------------------------------------------------------------------
module persiana_ctrl_multi #(
   parameter int unsigned NUM_POS    = 3,
   parameter int unsigned POS_W      = 2,
   parameter int unsigned PRESC_DIV  = 25000000,
   parameter int unsigned TIMEOUT_TK = 20,
   parameter int unsigned DEAD_TK    = 2
) (
   input  logic               clk,
   input  logic               reseteo,
   input  logic               cmd_valid,
   input  logic [POS_W-1:0]   cmd_pos,
   input  logic               cmd_auto,
   input  logic [1:0]         sensor,
   input  logic [NUM_POS-1:0] pos_sens,
   output logic               subir,
   output logic               bajar,
   output logic               tick,
   output logic               busy,
   output logic               fault,
   output logic [POS_W-1:0]   cur_pos
);

   localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam int unsigned TO_W    = (TIMEOUT_TK > 1) ? $clog2(TIMEOUT_TK) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_TK - 1);
   localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(NUM_POS - 1);
   localparam logic [POS_W-1:0]   POS_MID    = POS_W'(NUM_POS / 2);

   if ((NUM_POS < 2) || (NUM_POS > 8) || ((2 ** POS_W) < NUM_POS) || (PRESC_DIV < 2) ||
       (TIMEOUT_TK < 1) || (DEAD_TK < 1)) begin : g_param_check
      $error("persiana_ctrl_multi: parameter out of range");
   end

   typedef enum logic [2:0] {
      StIdle,
      StUp,
      StDown,
      StFault
`ifdef PERSIANA_DEADTIME_EN
      , StDead
`endif
   } state_e;

   // ---------------------------------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------------------------------
   logic [PRESC_W-1:0] presc_q;

   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         presc_q <= '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PRESC_W'(1);
      end
   end

   assign tick = (presc_q == PRESC_LAST);

   // ---------------------------------------------------------------------------------------------
   // Position sensor decode
   // ---------------------------------------------------------------------------------------------
   logic [3:0]       sens_cnt;
   logic [POS_W-1:0] sens_idx;
   logic             sens_one;
   logic             sens_multi;

   always_comb begin
      sens_cnt = '0;
      sens_idx = '0;
      for (int unsigned i = 0; i < NUM_POS; i++) begin
         if (pos_sens[i]) begin
            sens_cnt = sens_cnt + 4'd1;
            sens_idx = POS_W'(i);
         end
      end
   end

   assign sens_one   = (sens_cnt == 4'd1);
   assign sens_multi = (sens_cnt > 4'd1);

   // ---------------------------------------------------------------------------------------------
   // Target, auto mode and current position
   // ---------------------------------------------------------------------------------------------
   logic [POS_W-1:0] target_q;
   logic             auto_q;
   logic [POS_W-1:0] cmd_clamp;
   logic [POS_W-1:0] light_target;

   assign cmd_clamp = (cmd_pos > POS_MAX) ? POS_MAX : cmd_pos;

   always_comb begin
      case (sensor)
         2'b00:   light_target = '0;
         2'b01:   light_target = POS_MID;
         default: light_target = POS_MAX;
      endcase
   end

   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         target_q <= '0;
         auto_q   <= 1'b0;
         cur_pos  <= '0;
      end else begin
         // A command always beats a coincident auto tick.
         if (cmd_valid) begin
            if (cmd_auto) begin
               auto_q <= 1'b1;
            end else begin
               auto_q   <= 1'b0;
               target_q <= cmd_clamp;
            end
         end else if (tick && auto_q && (sensor != 2'b11)) begin
            target_q <= light_target;
         end
         if (sens_one) begin
            cur_pos <= sens_idx;
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Motion FSM
   // ---------------------------------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            rev_up_q, rev_up_d;   // direction to take after a reversal pause
`ifdef PERSIANA_DEADTIME_EN
   localparam int unsigned DEAD_W = (DEAD_TK > 0) ? $clog2(DEAD_TK + 1) : 1;
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TK);
   logic [DEAD_W-1:0] dead_q, dead_d;
`else
   logic            rev_q, rev_d;         // set for the single IDLE clock of a reversal
`endif

   logic at_target;
   logic tgt_above;
   logic tgt_below;
   logic to_expired;
   logic busy_d;

   assign at_target  = pos_sens[target_q];
   assign tgt_above  = (target_q > cur_pos);
   assign tgt_below  = (target_q < cur_pos);
   assign to_expired = tick && (to_q == TO_LAST);

   always_comb begin
      state_d  = state_q;
      to_d     = to_q;
      rev_up_d = rev_up_q;
`ifdef PERSIANA_DEADTIME_EN
      dead_d   = dead_q;
`else
      rev_d    = 1'b0;
`endif
      if (state_q == StFault) begin
         if (cmd_valid) begin
            state_d = StIdle;
         end
      end else if (sens_multi) begin
         state_d = StFault;
      end else begin
         case (state_q)
            StIdle: begin
`ifndef PERSIANA_DEADTIME_EN
               if (rev_q) begin
                  state_d = rev_up_q ? StUp : StDown;
                  to_d    = '0;
               end else
`endif
               if (tgt_above) begin
                  state_d = StUp;
                  to_d    = '0;
               end else if (tgt_below) begin
                  state_d = StDown;
                  to_d    = '0;
               end
            end
            StUp, StDown: begin
               if (at_target) begin
                  state_d = StIdle;
               end else if ((state_q == StUp) ? pos_sens[NUM_POS-1] : pos_sens[0]) begin
                  // Reached the mechanical end without passing the target.
                  state_d = StFault;
               end else if (to_expired) begin
                  state_d = StFault;
               end else if ((state_q == StUp) ? !tgt_above : !tgt_below) begin
                  // Target now lies behind us: pause with the motor off, then reverse.
                  rev_up_d = (state_q == StDown);
`ifdef PERSIANA_DEADTIME_EN
                  state_d  = StDead;
                  dead_d   = '0;
`else
                  state_d  = StIdle;
                  rev_d    = 1'b1;
`endif
               end else if (tick) begin
                  to_d = to_q + TO_W'(1);
               end
            end
`ifdef PERSIANA_DEADTIME_EN
            StDead: begin
               // The first tick seen only aligns to the tick grid, so DEAD_TK complete tick
               // periods elapse before the motor restarts.
               if (tick) begin
                  if (dead_q == DEAD_LAST) begin
                     state_d = rev_up_q ? StUp : StDown;
                     to_d    = '0;
                  end else begin
                     dead_d = dead_q + DEAD_W'(1);
                  end
               end
            end
`endif
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy_d = (state_d == StUp) || (state_d == StDown);
`ifdef PERSIANA_DEADTIME_EN
      busy_d = busy_d || (state_d == StDead);
`endif
   end

   always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
         state_q  <= StIdle;
         to_q     <= '0;
         rev_up_q <= 1'b0;
`ifdef PERSIANA_DEADTIME_EN
         dead_q   <= '0;
`else
         rev_q    <= 1'b0;
`endif
         subir    <= 1'b0;
         bajar    <= 1'b0;
         busy     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_q     <= to_d;
         rev_up_q <= rev_up_d;
`ifdef PERSIANA_DEADTIME_EN
         dead_q   <= dead_d;
`else
         rev_q    <= rev_d;
`endif
         subir    <= (state_d == StUp);
         bajar    <= (state_d == StDown);
         busy     <= busy_d;
         fault    <= (state_d == StFault);
      end
   end

endmodule
